// File: rtl/clkgen_pkg.sv
// Shared types and limits for the fractional clock-enable generator.
// Optional feature macro used by this slice: CLKEN_PHASE_OUT_EN.
package clkgen_pkg;

  localparam int MAX_CHANNELS = 8;
  localparam int CH_IDX_W     = $clog2(MAX_CHANNELS);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } state_t;

endpackage

// File: rtl/frac_clken_gen_if.sv
// Configuration, lock input and enable outputs of frac_clken_gen.
// CLKEN_PHASE_OUT_EN adds the half-period-shifted enable clken_p.
interface frac_clken_gen_if #(
  parameter int CHANNELS = 2,
  parameter int ACC_W    = 16
);

  logic                             pll_lock;
  logic                             cfg_we;
  logic [clkgen_pkg::CH_IDX_W-1:0]  cfg_ch;
  logic [ACC_W-1:0]                 cfg_inc;
  logic [ACC_W-1:0]                 cfg_mod;
  logic [CHANNELS-1:0]              clken;
  logic                             rstn_out;
  logic                             ready;
`ifdef CLKEN_PHASE_OUT_EN
  logic [CHANNELS-1:0]              clken_p;
`endif

  modport master (
    output pll_lock, cfg_we, cfg_ch, cfg_inc, cfg_mod,
`ifdef CLKEN_PHASE_OUT_EN
    input  clken_p,
`endif
    input  clken, rstn_out, ready
  );

  modport slave (
    input  pll_lock, cfg_we, cfg_ch, cfg_inc, cfg_mod,
`ifdef CLKEN_PHASE_OUT_EN
    output clken_p,
`endif
    output clken, rstn_out, ready
  );

endinterface

// File: rtl/frac_acc.sv
// One channel: fractional accumulator, wrap compare and config load.
// CLKEN_PHASE_OUT_EN adds o_clken_p, fired when acc crosses mod/2.
module frac_acc #(
  parameter int ACC_W   = 16,
  parameter int DEF_INC = 4,
  parameter int DEF_MOD = 9
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_run,
  input  logic             i_wr,
  input  logic [ACC_W-1:0] i_inc,
  input  logic [ACC_W-1:0] i_mod,
`ifdef CLKEN_PHASE_OUT_EN
  output logic             o_clken_p,
`endif
  output logic             o_clken
);

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_inc;
  logic [ACC_W-1:0] r_mod;
  logic             r_clken;

  logic [ACC_W:0]   w_sum;
  logic             w_hit;
  logic [ACC_W-1:0] w_acc_next;

  // A zero modulus disables the channel instead of matching every cycle.
  assign w_sum      = {1'b0, r_acc} + {1'b0, r_inc};
  assign w_hit      = (r_mod != '0) && (w_sum >= {1'b0, r_mod});
  assign w_acc_next = (r_mod == '0) ? '0 :
                      w_hit ? (w_sum[ACC_W-1:0] - r_mod) : w_sum[ACC_W-1:0];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_acc   <= '0;
      r_inc   <= ACC_W'(DEF_INC);
      r_mod   <= ACC_W'(DEF_MOD);
      r_clken <= 1'b0;
    end else if (i_wr) begin
      r_inc   <= i_inc;
      r_mod   <= i_mod;
      r_acc   <= '0;
      r_clken <= 1'b0;
    end else if (i_run) begin
      r_acc   <= w_acc_next;
      r_clken <= w_hit;
    end else begin
      r_acc   <= '0;
      r_clken <= 1'b0;
    end
  end

  assign o_clken = r_clken;

`ifdef CLKEN_PHASE_OUT_EN
  logic [ACC_W-1:0] w_half;
  logic             r_clken_p;

  assign w_half = r_mod >> 1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_clken_p <= 1'b0;
    end else if (i_wr || !i_run) begin
      r_clken_p <= 1'b0;
    end else begin
      r_clken_p <= (r_acc < w_half) && (w_acc_next >= w_half);
    end
  end

  assign o_clken_p = r_clken_p;
`endif

endmodule

// File: rtl/frac_clken_gen.sv
// Lock-qualified fractional clock-enable generator with CHANNELS outputs.
// CLKEN_PHASE_OUT_EN adds per-channel half-period enables on bus.clken_p.
module frac_clken_gen
  import clkgen_pkg::*;
#(
  parameter int CHANNELS    = 2,
  parameter int ACC_W       = 16,
  parameter int LOCK_CYCLES = 1024,
  parameter int DEF_INC     = 4,
  parameter int DEF_MOD     = 9
) (
  input logic              clk,
  input logic              resetn,
  frac_clken_gen_if.slave  bus
);

  localparam int CNT_W = $clog2(LOCK_CYCLES + 1);

  logic             r_lock_s1;
  logic             r_lock_s2;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ready;
  logic             r_rstn_out;

  logic                w_run;
  logic [CHANNELS-1:0] w_wr;
  logic [CHANNELS-1:0] w_clken;

  // Sync flops live here so the FSM and synchroniser share one reset path.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_lock_s1  <= 1'b0;
      r_lock_s2  <= 1'b0;
      r_state    <= WAIT_LOCK;
      r_cnt      <= '0;
      r_ready    <= 1'b0;
      r_rstn_out <= 1'b0;
    end else begin
      r_lock_s1 <= bus.pll_lock;
      r_lock_s2 <= r_lock_s1;
      case (r_state)
        WAIT_LOCK: begin
          if (r_lock_s2) begin
            r_state <= SETTLE;
            r_cnt   <= '0;
          end
        end
        SETTLE: begin
          if (!r_lock_s2) begin
            r_state <= WAIT_LOCK;
          end else if (r_cnt == CNT_W'(LOCK_CYCLES - 1)) begin
            r_state    <= RUN;
            r_ready    <= 1'b1;
            r_rstn_out <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        RUN: begin
          if (!r_lock_s2) begin
            r_state    <= WAIT_LOCK;
            r_ready    <= 1'b0;
            r_rstn_out <= 1'b0;
          end
        end
        default: begin
          r_state    <= WAIT_LOCK;
          r_ready    <= 1'b0;
          r_rstn_out <= 1'b0;
        end
      endcase
    end
  end

  // Gating on lock clears the accumulators on the very edge RUN is left.
  assign w_run = (r_state == RUN) && r_lock_s2;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    assign w_wr[g] = bus.cfg_we && (bus.cfg_ch == CH_IDX_W'(g));

    frac_acc #(
      .ACC_W   (ACC_W),
      .DEF_INC (DEF_INC),
      .DEF_MOD (DEF_MOD)
    ) u_acc (
      .clk       (clk),
      .resetn    (resetn),
      .i_run     (w_run),
      .i_wr      (w_wr[g]),
      .i_inc     (bus.cfg_inc),
      .i_mod     (bus.cfg_mod),
`ifdef CLKEN_PHASE_OUT_EN
      .o_clken_p (bus.clken_p[g]),
`endif
      .o_clken   (w_clken[g])
    );
  end

  assign bus.clken    = w_clken;
  assign bus.ready    = r_ready;
  assign bus.rstn_out = r_rstn_out;

endmodule

// File: tb/tb_frac_clken_gen.sv
// Directed bench for frac_clken_gen (CHANNELS=2, LOCK_CYCLES=4, defaults 4/9).
// With CLKEN_PHASE_OUT_EN defined, the phase-enable scenario is also run.
module tb_frac_clken_gen;

  logic clk;
  logic resetn;

  int tests_run;
  int tests_failed;
  int ph0;

  // Default 4/9 clken sequence, starting from acc=0 on the first RUN edge.
  bit pat9 [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  frac_clken_gen_if #(.CHANNELS(2), .ACC_W(16)) bus ();

  frac_clken_gen #(
    .CHANNELS    (2),
    .ACC_W       (16),
    .LOCK_CYCLES (4),
    .DEF_INC     (4),
    .DEF_MOD     (9)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Issues a one-cycle config write; returns at the negedge after it lands.
  task automatic applyStimulus(input logic [2:0] ch, input logic [15:0] inc,
                               input logic [15:0] md);
    bus.cfg_we  = 1'b1;
    bus.cfg_ch  = ch;
    bus.cfg_inc = inc;
    bus.cfg_mod = md;
    tick();
    bus.cfg_we  = 1'b0;
  endtask

  task automatic test_reset;
    bus.pll_lock = 1'b1;
    bus.cfg_we   = 1'b0;
    bus.cfg_ch   = 3'd0;
    bus.cfg_inc  = 16'd0;
    bus.cfg_mod  = 16'd0;
    resetn       = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (bus.ready !== 1'b0 || bus.rstn_out !== 1'b0 || bus.clken !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL reset_state: ready=%b rstn_out=%b clken=%b expected 0 0 00",
               bus.ready, bus.rstn_out, bus.clken);
    end
    resetn = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      tests_run++;
      if (bus.ready !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL settle_ready_low edge %0d: ready=%b expected 0", k, bus.ready);
      end
    end
    tick();
    tests_run++;
    if (bus.ready !== 1'b1 || bus.rstn_out !== 1'b1 || bus.clken !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL ready_rise edge 7: ready=%b rstn_out=%b clken=%b expected 1 1 00",
               bus.ready, bus.rstn_out, bus.clken);
    end
    ph0 = 0;
  endtask

  task automatic test_default_pattern;
    int pulses;
    pulses = 0;
    for (int k = 0; k < 18; k++) begin
      tick();
      tests_run++;
      if (bus.clken !== {pat9[ph0], pat9[ph0]}) begin
        tests_failed++;
        $display("[TB] FAIL default_pattern step %0d: clken=%b expected %b%b",
                 k, bus.clken, pat9[ph0], pat9[ph0]);
      end
      if (bus.clken[0] === 1'b1) pulses++;
      ph0 = (ph0 + 1) % 9;
    end
    tests_run++;
    if (pulses != 8) begin
      tests_failed++;
      $display("[TB] FAIL default_pulse_count: got %0d pulses in 18 cycles expected 8", pulses);
    end
  endtask

  task automatic test_cfg_ch1;
    applyStimulus(3'd1, 16'd1, 16'd1);
    tests_run++;
    if (bus.clken !== {1'b0, pat9[ph0]}) begin
      tests_failed++;
      $display("[TB] FAIL cfg_write_cycle: clken=%b expected 0%b", bus.clken, pat9[ph0]);
    end
    ph0 = (ph0 + 1) % 9;
    for (int k = 0; k < 9; k++) begin
      tick();
      tests_run++;
      if (bus.clken !== {1'b1, pat9[ph0]}) begin
        tests_failed++;
        $display("[TB] FAIL ch1_every_cycle step %0d: clken=%b expected 1%b",
                 k, bus.clken, pat9[ph0]);
      end
      ph0 = (ph0 + 1) % 9;
    end
  endtask

  task automatic test_bad_ch;
    applyStimulus(3'd0, 16'd4, 16'd0);
    tests_run++;
    if (bus.clken !== 2'b10) begin
      tests_failed++;
      $display("[TB] FAIL mod0_write_cycle: clken=%b expected 10", bus.clken);
    end
    applyStimulus(3'd5, 16'd3, 16'd7);
    for (int k = 0; k < 9; k++) begin
      tests_run++;
      if (bus.clken !== 2'b10) begin
        tests_failed++;
        $display("[TB] FAIL mod0_and_ch5_ignored step %0d: clken=%b expected 10", k, bus.clken);
      end
      tick();
    end
    applyStimulus(3'd0, 16'd4, 16'd9);
    tests_run++;
    if (bus.clken !== 2'b10) begin
      tests_failed++;
      $display("[TB] FAIL ch0_restore_cycle: clken=%b expected 10", bus.clken);
    end
    ph0 = 0;
    for (int k = 0; k < 9; k++) begin
      tick();
      tests_run++;
      if (bus.clken !== {1'b1, pat9[ph0]}) begin
        tests_failed++;
        $display("[TB] FAIL ch0_restored step %0d: clken=%b expected 1%b",
                 k, bus.clken, pat9[ph0]);
      end
      ph0 = (ph0 + 1) % 9;
    end
  endtask

  task automatic test_lock_drop;
    bus.pll_lock = 1'b0;
    tick();
    bus.pll_lock = 1'b1;
    tick();
    tick();
    tests_run++;
    if (bus.ready !== 1'b0 || bus.rstn_out !== 1'b0 || bus.clken !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL lock_drop_outputs: ready=%b rstn_out=%b clken=%b expected 0 0 00",
               bus.ready, bus.rstn_out, bus.clken);
    end
    for (int k = 4; k <= 7; k++) begin
      tick();
      tests_run++;
      if (bus.ready !== 1'b0 || bus.clken !== 2'b00) begin
        tests_failed++;
        $display("[TB] FAIL relock_settle edge %0d: ready=%b clken=%b expected 0 00",
                 k, bus.ready, bus.clken);
      end
    end
    tick();
    tests_run++;
    if (bus.ready !== 1'b1 || bus.rstn_out !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL relock_ready: ready=%b rstn_out=%b expected 1 1",
               bus.ready, bus.rstn_out);
    end
    ph0 = 0;
    for (int k = 0; k < 9; k++) begin
      tick();
      tests_run++;
      if (bus.clken !== {1'b1, pat9[ph0]}) begin
        tests_failed++;
        $display("[TB] FAIL relock_pattern step %0d: clken=%b expected 1%b",
                 k, bus.clken, pat9[ph0]);
      end
      ph0 = (ph0 + 1) % 9;
    end
  endtask

`ifdef CLKEN_PHASE_OUT_EN
  task automatic test_phase;
    bit exp_c [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    bit exp_p [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    applyStimulus(3'd0, 16'd1, 16'd4);
    for (int k = 0; k < 8; k++) begin
      tick();
      tests_run++;
      if (bus.clken[0] !== exp_c[k] || bus.clken_p[0] !== exp_p[k]) begin
        tests_failed++;
        $display("[TB] FAIL phase_out step %0d: clken0=%b clken_p0=%b expected %b %b",
                 k, bus.clken[0], bus.clken_p[0], exp_c[k], exp_p[k]);
      end
    end
  endtask
`endif

  task automatic test_async_reset;
    tests_run++;
    if (bus.ready !== 1'b1 || bus.clken[1] !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL pre_reset_run: ready=%b clken1=%b expected 1 1",
               bus.ready, bus.clken[1]);
    end
    #2 resetn = 1'b0;
    #1;
    tests_run++;
    if (bus.ready !== 1'b0 || bus.rstn_out !== 1'b0 || bus.clken !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL async_reset_outputs: ready=%b rstn_out=%b clken=%b expected 0 0 00",
               bus.ready, bus.rstn_out, bus.clken);
    end
    @(negedge clk);
    resetn = 1'b1;
    repeat (6) tick();
    tests_run++;
    if (bus.ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL post_reset_settle: ready=%b expected 0", bus.ready);
    end
    tick();
    tests_run++;
    if (bus.ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL post_reset_ready: ready=%b expected 1", bus.ready);
    end
    ph0 = 0;
    for (int k = 0; k < 9; k++) begin
      tick();
      tests_run++;
      if (bus.clken !== {pat9[ph0], pat9[ph0]}) begin
        tests_failed++;
        $display("[TB] FAIL defaults_restored step %0d: clken=%b expected %b%b",
                 k, bus.clken, pat9[ph0], pat9[ph0]);
      end
      ph0 = (ph0 + 1) % 9;
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    ph0          = 0;
    test_reset();
    test_default_pattern();
    test_cfg_ch1();
    test_bad_ch();
    test_lock_drop();
`ifdef CLKEN_PHASE_OUT_EN
    test_phase();
`endif
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
